// File: rtl/vector_test_sequencer_if.sv
// Bus bundle between the vector test sequencer and its driver: load port, run control, DUT stimulus/response and status.
// Fail-log signals exist only when VECSEQ_FAILLOG_EN is defined.
interface vector_test_sequencer_if #(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 1,
  parameter int ADDR_W = 4,
  parameter int ERR_W  = 16
);
  logic                    load_en;
  logic [ADDR_W-1:0]       load_addr;
  logic [IN_W+OUT_W-1:0]   load_data;
  logic                    start;
  logic [IN_W-1:0]         dut_in;
  logic [OUT_W-1:0]        dut_out;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic [ERR_W-1:0]        err_count;
  logic [ADDR_W:0]         vec_count;
`ifdef VECSEQ_FAILLOG_EN
  logic                    fail_valid;
  logic [ADDR_W-1:0]       fail_idx;
  logic [IN_W-1:0]         fail_in;
  logic [OUT_W-1:0]        fail_got;
`endif

  modport master (
    output load_en, load_addr, load_data, start, dut_out,
`ifdef VECSEQ_FAILLOG_EN
    input  fail_valid, fail_idx, fail_in, fail_got,
`endif
    input  dut_in, busy, done, pass, err_count, vec_count
  );

  modport slave (
    input  load_en, load_addr, load_data, start, dut_out,
`ifdef VECSEQ_FAILLOG_EN
    output fail_valid, fail_idx, fail_in, fail_got,
`endif
    output dut_in, busy, done, pass, err_count, vec_count
  );
endinterface

// File: rtl/vector_test_sequencer.sv
// On-chip vector tester: applies stored {in, expected} vectors to a combinational DUT and counts mismatches.
// Optional first-failure capture is enabled with the VECSEQ_FAILLOG_EN macro.
module vector_test_sequencer #(
  parameter int IN_W       = 3,
  parameter int OUT_W      = 1,
  parameter int NVEC       = 16,
  parameter int ADDR_W     = 4,
  parameter int SETTLE_CYC = 1,
  parameter int ERR_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  vector_test_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

  localparam int VEC_W = IN_W + OUT_W;
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NVEC - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   VEC_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1);
  localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_t                state, state_next;
  logic [VEC_W-1:0]      mem [NVEC];
  logic [NVEC-1:0]       valid;
  logic [VEC_W-1:0]      entry;
  logic [ADDR_W-1:0]     index;
  logic [IN_W-1:0]       dut_in_r;
  logic [OUT_W-1:0]      expected;
  logic [3:0]            settle_cnt;
  logic [ERR_W-1:0]      err_count_r;
  logic [ADDR_W:0]       vec_count_r;
  logic                  write_ok;
  logic                  mismatch;

  assign entry    = mem[index];
  assign mismatch = (bus.dut_out != expected);

  always_comb begin
    state_next = state;
    write_ok   = 1'b0;
    case (state)
      IDLE, DONE: begin
        write_ok = 1'b1;
        if (bus.start) state_next = APPLY;
      end
      APPLY:   state_next = valid[index] ? SETTLE : DONE;
      SETTLE:  if (settle_cnt == 4'd0) state_next = CHECK;
      CHECK:   state_next = (index == IDX_LAST) ? DONE : APPLY;
      default: state_next = IDLE;
    endcase
  end

  // Vector data has no reset so it can map onto RAM; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (bus.load_en && write_ok) mem[bus.load_addr] <= bus.load_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      valid       <= '0;
      index       <= '0;
      dut_in_r    <= '0;
      expected    <= '0;
      settle_cnt  <= '0;
      err_count_r <= '0;
      vec_count_r <= '0;
    end else begin
      state <= state_next;
      if (bus.load_en && write_ok) valid[bus.load_addr] <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            index       <= '0;
            err_count_r <= '0;
            vec_count_r <= '0;
          end
        end
        APPLY: begin
          if (valid[index]) begin
            dut_in_r   <= entry[VEC_W-1:OUT_W];
            expected   <= entry[OUT_W-1:0];
            settle_cnt <= SETTLE_LOAD;
          end
        end
        SETTLE: if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        CHECK: begin
          if (mismatch && (err_count_r != '1)) err_count_r <= err_count_r + ERR_ONE;
          vec_count_r <= vec_count_r + VEC_ONE;
          if (index != IDX_LAST) index <= index + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

`ifdef VECSEQ_FAILLOG_EN
  logic              fail_valid_r;
  logic [ADDR_W-1:0] fail_idx_r;
  logic [IN_W-1:0]   fail_in_r;
  logic [OUT_W-1:0]  fail_got_r;

  // Only the first mismatch of a run is latched; later ones leave it alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fail_valid_r <= 1'b0;
      fail_idx_r   <= '0;
      fail_in_r    <= '0;
      fail_got_r   <= '0;
    end else if ((state == IDLE || state == DONE) && bus.start) begin
      fail_valid_r <= 1'b0;
      fail_idx_r   <= '0;
      fail_in_r    <= '0;
      fail_got_r   <= '0;
    end else if (state == CHECK && mismatch && !fail_valid_r) begin
      fail_valid_r <= 1'b1;
      fail_idx_r   <= index;
      fail_in_r    <= dut_in_r;
      fail_got_r   <= bus.dut_out;
    end
  end

  assign bus.fail_valid = fail_valid_r;
  assign bus.fail_idx   = fail_idx_r;
  assign bus.fail_in    = fail_in_r;
  assign bus.fail_got   = fail_got_r;
`endif

  assign bus.dut_in    = dut_in_r;
  assign bus.busy      = (state == APPLY) || (state == SETTLE) || (state == CHECK);
  assign bus.done      = (state == DONE);
  assign bus.pass      = (state == DONE) && (err_count_r == '0) && (vec_count_r != '0);
  assign bus.err_count = err_count_r;
  assign bus.vec_count = vec_count_r;

endmodule

// File: tb/tb_vector_test_sequencer.sv
// Directed bench for vector_test_sequencer: instance A uses defaults, instance B uses ERR_W=2 for saturation.
// Fail-log checks are compiled in when VECSEQ_FAILLOG_EN is defined.
module tb_vector_test_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  vector_test_sequencer_if #(.ERR_W(16)) busA ();
  vector_test_sequencer_if #(.ERR_W(2))  busB ();

  vector_test_sequencer #(.ERR_W(16)) dutA (.clk(clk), .reset(reset), .bus(busA));
  vector_test_sequencer #(.ERR_W(2))  dutB (.clk(clk), .reset(reset), .bus(busB));

  // Reference combinational DUT: y = ~b&~c | a&~b with in = {a,b,c}.
  function automatic logic ref_y(input logic [2:0] v);
    return (~v[1] & ~v[0]) | (v[2] & ~v[1]);
  endfunction

  assign busA.dut_out = ref_y(busA.dut_in);
  assign busB.dut_out = ~ref_y(busB.dut_in);

  logic [3:0] good_vecs [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_a(input logic [3:0] addr, input logic [3:0] data);
    busA.load_en = 1'b1; busA.load_addr = addr; busA.load_data = data;
    @(posedge clk); #1;
    busA.load_en = 1'b0;
  endtask

  task automatic load_good_a();
    for (int i = 0; i < 8; i++) load_a(4'(i), good_vecs[i]);
  endtask

  task automatic start_a();
    busA.start = 1'b1;
    @(posedge clk); #1;
    busA.start = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic wait_done_a(input int from, output int cyc);
    cyc = from;
    while (busA.done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (busA.done !== 1'b1) begin
      $display("[TB] FAIL done_timeout got done=%b want 1", busA.done);
      bad++; total++;
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    total += 6;
    if (busA.busy !== 1'b0) begin $display("[TB] FAIL rst_busy got %b want 0", busA.busy); bad++; end
    if (busA.done !== 1'b0) begin $display("[TB] FAIL rst_done got %b want 0", busA.done); bad++; end
    if (busA.pass !== 1'b0) begin $display("[TB] FAIL rst_pass got %b want 0", busA.pass); bad++; end
    if (busA.err_count !== 16'd0) begin $display("[TB] FAIL rst_err got %0d want 0", busA.err_count); bad++; end
    if (busA.vec_count !== 5'd0) begin $display("[TB] FAIL rst_vec got %0d want 0", busA.vec_count); bad++; end
    if (busA.dut_in !== 3'd0) begin $display("[TB] FAIL rst_dut_in got %b want 000", busA.dut_in); bad++; end
`ifdef VECSEQ_FAILLOG_EN
    total++;
    if (busA.fail_valid !== 1'b0) begin $display("[TB] FAIL rst_fail_valid got %b want 0", busA.fail_valid); bad++; end
`endif
  endtask

  task automatic test_basic_run();
    int cyc;
    $display("[TB] test_basic_run");
    load_good_a();
    start_a();
    wait_done_a(1, cyc);
    total += 6;
    if (cyc != 26) begin $display("[TB] FAIL basic_latency got %0d want 26", cyc); bad++; end
    if (busA.err_count !== 16'd0) begin $display("[TB] FAIL basic_err got %0d want 0", busA.err_count); bad++; end
    if (busA.vec_count !== 5'd8) begin $display("[TB] FAIL basic_vec got %0d want 8", busA.vec_count); bad++; end
    if (busA.pass !== 1'b1) begin $display("[TB] FAIL basic_pass got %b want 1", busA.pass); bad++; end
    if (busA.busy !== 1'b0) begin $display("[TB] FAIL basic_busy got %b want 0", busA.busy); bad++; end
    if (busA.dut_in !== 3'b111) begin $display("[TB] FAIL basic_dut_in_hold got %b want 111", busA.dut_in); bad++; end
  endtask

  task automatic test_wrong_expected();
    int cyc;
    $display("[TB] test_wrong_expected");
    load_a(4'd2, 4'b0101);
    start_a();
    total += 2;
    if (busA.done !== 1'b0) begin $display("[TB] FAIL restart_done got %b want 0", busA.done); bad++; end
    if (busA.busy !== 1'b1) begin $display("[TB] FAIL restart_busy got %b want 1", busA.busy); bad++; end
    wait_done_a(1, cyc);
    total += 4;
    if (cyc != 26) begin $display("[TB] FAIL wrong_latency got %0d want 26", cyc); bad++; end
    if (busA.err_count !== 16'd1) begin $display("[TB] FAIL wrong_err got %0d want 1", busA.err_count); bad++; end
    if (busA.vec_count !== 5'd8) begin $display("[TB] FAIL wrong_vec got %0d want 8", busA.vec_count); bad++; end
    if (busA.pass !== 1'b0) begin $display("[TB] FAIL wrong_pass got %b want 0", busA.pass); bad++; end
`ifdef VECSEQ_FAILLOG_EN
    total += 4;
    if (busA.fail_valid !== 1'b1) begin $display("[TB] FAIL flog_valid got %b want 1", busA.fail_valid); bad++; end
    if (busA.fail_idx !== 4'd2) begin $display("[TB] FAIL flog_idx got %0d want 2", busA.fail_idx); bad++; end
    if (busA.fail_in !== 3'b010) begin $display("[TB] FAIL flog_in got %b want 010", busA.fail_in); bad++; end
    if (busA.fail_got !== 1'b0) begin $display("[TB] FAIL flog_got got %b want 0", busA.fail_got); bad++; end
`endif
  endtask

  task automatic test_empty();
    int cyc;
    $display("[TB] test_empty");
    pulse_reset();
    start_a();
    wait_done_a(1, cyc);
    total += 5;
    if (cyc != 2) begin $display("[TB] FAIL empty_latency got %0d want 2", cyc); bad++; end
    if (busA.vec_count !== 5'd0) begin $display("[TB] FAIL empty_vec got %0d want 0", busA.vec_count); bad++; end
    if (busA.err_count !== 16'd0) begin $display("[TB] FAIL empty_err got %0d want 0", busA.err_count); bad++; end
    if (busA.pass !== 1'b0) begin $display("[TB] FAIL empty_pass got %b want 0", busA.pass); bad++; end
    if (busA.dut_in !== 3'd0) begin $display("[TB] FAIL empty_dut_in got %b want 000", busA.dut_in); bad++; end
  endtask

  task automatic test_full();
    int cyc;
    logic [2:0] v;
    $display("[TB] test_full");
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      v = 3'(i);
      load_a(4'(i), {v, ref_y(v)});
    end
    start_a();
    wait_done_a(1, cyc);
    total += 4;
    if (cyc != 49) begin $display("[TB] FAIL full_latency got %0d want 49", cyc); bad++; end
    if (busA.vec_count !== 5'd16) begin $display("[TB] FAIL full_vec got %0d want 16", busA.vec_count); bad++; end
    if (busA.pass !== 1'b1) begin $display("[TB] FAIL full_pass got %b want 1", busA.pass); bad++; end
    if (busA.busy !== 1'b0) begin $display("[TB] FAIL full_busy got %b want 0", busA.busy); bad++; end
    repeat (5) @(posedge clk);
    #1;
    total += 2;
    if (busA.vec_count !== 5'd16) begin $display("[TB] FAIL full_nowrap_vec got %0d want 16", busA.vec_count); bad++; end
    if (busA.done !== 1'b1) begin $display("[TB] FAIL full_done_hold got %b want 1", busA.done); bad++; end
  endtask

  task automatic test_abort();
    int cyc;
    $display("[TB] test_abort");
    pulse_reset();
    load_good_a();
    start_a();
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total += 5;
    if (busA.busy !== 1'b0) begin $display("[TB] FAIL abort_busy got %b want 0", busA.busy); bad++; end
    if (busA.done !== 1'b0) begin $display("[TB] FAIL abort_done got %b want 0", busA.done); bad++; end
    if (busA.err_count !== 16'd0) begin $display("[TB] FAIL abort_err got %0d want 0", busA.err_count); bad++; end
    if (busA.vec_count !== 5'd0) begin $display("[TB] FAIL abort_vec got %0d want 0", busA.vec_count); bad++; end
    if (busA.dut_in !== 3'd0) begin $display("[TB] FAIL abort_dut_in got %b want 000", busA.dut_in); bad++; end
    reset = 1'b1;
    start_a();
    wait_done_a(1, cyc);
    total += 2;
    if (cyc != 2) begin $display("[TB] FAIL abort_rerun_latency got %0d want 2", cyc); bad++; end
    if (busA.vec_count !== 5'd0) begin $display("[TB] FAIL abort_rerun_vec got %0d want 0", busA.vec_count); bad++; end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    $display("[TB] test_busy_ignore");
    pulse_reset();
    load_good_a();
    start_a();
    repeat (2) @(posedge clk);
    #1;
    busA.load_en = 1'b1; busA.load_addr = 4'd2; busA.load_data = 4'b0101; busA.start = 1'b1;
    @(posedge clk); #1;
    busA.load_addr = 4'd8; busA.load_data = 4'b1001; busA.start = 1'b0;
    @(posedge clk); #1;
    busA.load_en = 1'b0;
    wait_done_a(5, cyc);
    total += 3;
    if (cyc != 26) begin $display("[TB] FAIL busy_latency got %0d want 26", cyc); bad++; end
    if (busA.err_count !== 16'd0) begin $display("[TB] FAIL busy_err got %0d want 0", busA.err_count); bad++; end
    if (busA.vec_count !== 5'd8) begin $display("[TB] FAIL busy_vec got %0d want 8", busA.vec_count); bad++; end
    start_a();
    wait_done_a(1, cyc);
    total += 3;
    if (cyc != 26) begin $display("[TB] FAIL busy_rerun_latency got %0d want 26", cyc); bad++; end
    if (busA.err_count !== 16'd0) begin $display("[TB] FAIL busy_rerun_err got %0d want 0", busA.err_count); bad++; end
    if (busA.vec_count !== 5'd8) begin $display("[TB] FAIL busy_rerun_vec got %0d want 8", busA.vec_count); bad++; end
  endtask

  task automatic test_load_with_start();
    int cyc;
    $display("[TB] test_load_with_start");
    pulse_reset();
    busA.load_en = 1'b1; busA.load_addr = 4'd0; busA.load_data = 4'b0001; busA.start = 1'b1;
    @(posedge clk); #1;
    busA.load_en = 1'b0; busA.start = 1'b0;
    wait_done_a(1, cyc);
    total += 3;
    if (cyc != 5) begin $display("[TB] FAIL ldst_latency got %0d want 5", cyc); bad++; end
    if (busA.vec_count !== 5'd1) begin $display("[TB] FAIL ldst_vec got %0d want 1", busA.vec_count); bad++; end
    if (busA.pass !== 1'b1) begin $display("[TB] FAIL ldst_pass got %b want 1", busA.pass); bad++; end
  endtask

  task automatic test_saturate();
    int cyc;
    $display("[TB] test_saturate");
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      busB.load_en = 1'b1; busB.load_addr = 4'(i); busB.load_data = good_vecs[i];
      @(posedge clk); #1;
    end
    busB.load_en = 1'b0;
    busB.start = 1'b1;
    @(posedge clk); #1;
    busB.start = 1'b0;
    cyc = 1;
    while (busB.done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    total += 4;
    if (busB.done !== 1'b1) begin $display("[TB] FAIL sat_done got %b want 1", busB.done); bad++; end
    if (busB.err_count !== 2'd3) begin $display("[TB] FAIL sat_err got %0d want 3", busB.err_count); bad++; end
    if (busB.vec_count !== 5'd8) begin $display("[TB] FAIL sat_vec got %0d want 8", busB.vec_count); bad++; end
    if (busB.pass !== 1'b0) begin $display("[TB] FAIL sat_pass got %b want 0", busB.pass); bad++; end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    good_vecs = '{4'b0001, 4'b0010, 4'b0100, 4'b0110, 4'b1001, 4'b1011, 4'b1100, 4'b1110};
    busA.load_en = 1'b0; busA.load_addr = '0; busA.load_data = '0; busA.start = 1'b0;
    busB.load_en = 1'b0; busB.load_addr = '0; busB.load_data = '0; busB.start = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    test_basic_run();
    test_wrong_expected();
    test_empty();
    test_full();
    test_abort();
    test_busy_ignore();
    test_load_with_start();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_test_sequencer.md
Name: vector_test_sequencer

Overview:
Synthesizable self-test controller that sequences stored test vectors into a small combinational DUT, samples its output and compares it with the expected value. It holds a vector memory loaded over a simple write port. On a start pulse it steps through the vectors, counts mismatches and reports done and pass/fail. It is the on-chip equivalent of our vector-file benches, so block-level checks can run on silicon and FPGA.

Parameters:
IN_W, 3, DUT input width (bits applied per vector)
OUT_W, 1, DUT output width (expected bits per vector)
NVEC, 16, vector memory depth (power of 2)
ADDR_W, 4, log2(NVEC)
SETTLE_CYC, 1, wait cycles between applying a vector and sampling dut_out (range 1..15)
ERR_W, 16, error counter width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low
load_en  in  1  write strobe for vector memory
load_addr  in  ADDR_W  write address
load_data  in  IN_W+OUT_W  vector: inputs in MSBs {in, expected}
start  in  1  one-cycle run request
dut_in  out  IN_W  registered stimulus to DUT
dut_out  in  OUT_W  DUT response
busy  out  1  run in progress
done  out  1  run finished, held until next start
pass  out  1  valid with done: err_count==0 and vec_count>0
err_count  out  ERR_W  mismatch count, saturating
vec_count  out  ADDR_W+1  vectors checked this run

Behaviour:
- Reset (reset==0 at posedge): all outputs 0. State IDLE. Every memory valid bit cleared. Memory data is not cleared.
- Memory: NVEC entries, each data plus a valid bit. load_en in IDLE or DONE writes load_data and sets valid[load_addr]. load_en while busy is ignored. Entries are used from index 0 upward. The first entry with valid==0 is the end-of-test marker.
- States: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE/DONE, start==1: next state APPLY. Index=0, err_count=0, vec_count=0, done=0, pass=0, busy=1.
- APPLY (1 cycle):
  - If valid[index]==0: go to DONE.
  - Else: register dut_in<=entry[IN_W+OUT_W-1:OUT_W] and expected<=entry[OUT_W-1:0], load the settle counter, go to SETTLE.
- SETTLE: holds SETTLE_CYC cycles, dut_in stable, then go to CHECK.
- CHECK (1 cycle):
  - If dut_out!=expected: err_count increments, saturating at all-ones.
  - vec_count increments.
  - If index==NVEC-1: go to DONE (no wrap). Else index++ and go to APPLY.
- Per-vector latency: 2+SETTLE_CYC cycles. Empty memory reaches DONE 2 cycles after start.
- DONE: busy=0, done=1, pass=(err_count==0 && vec_count!=0). dut_in holds its last value. Outputs hold until start.
- start while busy: ignored.
- reset low mid-run: immediate return to reset values; the run is aborted with no done.
- load_en and start in the same cycle in IDLE: the write takes effect, and the run sees the new entry.

Optional Feature:
VECSEQ_FAILLOG_EN
- Defined:
  - Adds outputs fail_valid (1), fail_idx (ADDR_W), fail_in (IN_W), fail_got (OUT_W).
  - These capture the first mismatching vector of a run and are cleared at start and at reset.
  - Later mismatches do not overwrite them.
- Undefined: these ports and registers are absent; the rest of the behaviour is identical.

Test Plan:
- DUT y=~b&~c | a&~b. Load 8 vectors 0001,0010,0100,0110,1001,1011,1100,1110 at addr 0..7, then start -> done 2+8*3=26 cycles after start (SETTLE_CYC=1), err_count=0, vec_count=8, pass=1.
- Same vectors with addr 2 = 0101 (wrong expected) -> err_count=1, vec_count=8, pass=0. With VECSEQ_FAILLOG_EN: fail_valid=1, fail_idx=2, fail_in=010, fail_got=0.
- No loads after reset, start -> done after 2 cycles, vec_count=0, err_count=0, pass=0, dut_in=0.
- All 16 entries valid, start -> stops after 16 checks, vec_count=16, no wrap to index 0, busy=0.
- Run started with 8 vectors:
  - reset low at cycle 10 -> all outputs 0.
  - A following start with no reloads -> empty-memory result.
  - load_en and start pulses while busy -> memory unchanged and run unaffected.
- Vector with the DUT output forced to mismatch on every entry, ERR_W=2, 8 vectors -> err_count saturates at 3, vec_count=8.
